// File: rtl/zap_fetch_buffered_pkg.sv
// zap_fetch_buffered_pkg: shared constants and helpers for the buffered fetch stage.
package zap_fetch_buffered_pkg;

    localparam logic [31:0] FETCH_ABORT_PAYLOAD = 32'd0;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    // ARM reads PC as address+8, Thumb as address+4.
    function automatic logic [31:0] pc_plus_8(input logic [31:0] pc, input logic t);
        return pc + (t ? 32'd4 : 32'd8);
    endfunction

endpackage

// File: rtl/zap_bp_table.sv
// zap_bp_table: saturating-counter branch predictor table with reset,
// combinational read and synchronous update.
module zap_bp_table #(
    parameter int BP_ENTRIES = 1024,
    parameter int BP_CTR_W   = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [$clog2(BP_ENTRIES)-1:0] i_rd_idx,
    output logic [BP_CTR_W-1:0]           o_rd_state,
    input  logic                          i_wr_en,
    input  logic [$clog2(BP_ENTRIES)-1:0] i_wr_idx,
    input  logic [BP_CTR_W-1:0]           i_wr_state,
    input  logic                          i_wr_mispredict
);

    localparam logic [BP_CTR_W-1:0] ONE = BP_CTR_W'(1);
    localparam logic [BP_CTR_W-1:0] MAX = '1;

    logic [BP_CTR_W-1:0] mem [BP_ENTRIES];

    // A mispredict steps toward the other direction; a confirm saturates
    // further into the predicted direction.
    function automatic logic [BP_CTR_W-1:0] bp_next(input logic [BP_CTR_W-1:0] s, input logic misp);
        logic msb;
        msb = s[BP_CTR_W-1];
        if (misp)
            return msb ? s - ONE : s + ONE;
        return msb ? ((s == MAX) ? s : s + ONE) : ((s == '0) ? s : s - ONE);
    endfunction

    assign o_rd_state = mem[i_rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BP_ENTRIES; i++)
                mem[i] <= '0;
        end else if (i_wr_en) begin
            mem[i_wr_idx] <= bp_next(i_wr_state, i_wr_mispredict);
        end
    end

endmodule

// File: rtl/zap_fetch_buffered.sv
// zap_fetch_buffered: fetch stage with an instruction FIFO between the I-side
// and decode, carrying PC, abort and predictor state with each word.
module zap_fetch_buffered
    import zap_fetch_buffered_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BP_ENTRIES = 1024,
    parameter int BP_CTR_W   = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_stall,
    input  logic                i_valid,
    input  logic [31:0]         i_instruction,
    input  logic [31:0]         i_pc,
    input  logic                i_cpsr_t,
    input  logic                i_instr_abort,
    output logic                o_ready,
    output logic                o_valid,
    output logic [31:0]         o_instruction,
    output logic                o_instr_abort,
    output logic [31:0]         o_pc_ff,
    output logic [31:0]         o_pc_plus_8_ff,
    output logic [BP_CTR_W-1:0] o_taken_ff,
    input  logic                i_bp_confirm,
    input  logic                i_bp_mispredict,
    input  logic [31:0]         i_bp_pc,
    input  logic [BP_CTR_W-1:0] i_bp_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(BP_ENTRIES);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    logic [31:0]         instr_q [FIFO_DEPTH];
    logic [31:0]         pc_q    [FIFO_DEPTH];
    logic                t_q     [FIFO_DEPTH];
    logic                abort_q [FIFO_DEPTH];
    logic [BP_CTR_W-1:0] bp_q    [FIFO_DEPTH];

    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [PW:0]         count;
    logic                sleep;
    logic                push, pop;
    logic [BP_CTR_W-1:0] bp_rd;
    logic                _unused_ok_;

    assign o_ready = (count != FULL) & ~sleep;
    assign o_valid = (count != '0);
    assign push    = i_valid & o_ready & ~i_clear;
    assign pop     = o_valid & ~i_stall & ~i_clear;

    assign o_instruction  = o_valid ? instr_q[rd_ptr] : 32'd0;
    assign o_instr_abort  = o_valid & abort_q[rd_ptr];
    assign o_pc_ff        = o_valid ? pc_q[rd_ptr] : 32'd0;
    assign o_pc_plus_8_ff = o_valid ? pc_plus_8(pc_q[rd_ptr], t_q[rd_ptr]) : 32'd0;
    assign o_taken_ff     = o_valid ? bp_q[rd_ptr] : '0;

    // Sleep stops further fetch after an abort until the pipeline is flushed.
    always_ff @(posedge i_clk) begin
        if (i_reset | i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sleep  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (push & i_instr_abort)
                sleep <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_q[wr_ptr] <= i_instr_abort ? FETCH_ABORT_PAYLOAD : i_instruction;
            pc_q[wr_ptr]    <= i_pc;
            t_q[wr_ptr]     <= i_cpsr_t;
            abort_q[wr_ptr] <= i_instr_abort;
            bp_q[wr_ptr]    <= bp_rd;
        end
    end

    zap_bp_table #(
        .BP_ENTRIES (BP_ENTRIES),
        .BP_CTR_W   (BP_CTR_W)
    ) u_bp_table (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_rd_idx        (i_pc[IW:1]),
        .o_rd_state      (bp_rd),
        .i_wr_en         ((i_bp_confirm | i_bp_mispredict) & ~i_stall),
        .i_wr_idx        (i_bp_pc[IW:1]),
        .i_wr_state      (i_bp_state),
        .i_wr_mispredict (i_bp_mispredict)
    );

    assign _unused_ok_ = &{1'b0, i_pc[31:IW+1], i_pc[0], i_bp_pc[31:IW+1], i_bp_pc[0]};

endmodule

// File: tb/tb_zap_fetch_buffered.sv
// tb_zap_fetch_buffered: scoreboard bench for the buffered fetch stage and
// its branch predictor table.
module tb_zap_fetch_buffered;

    logic        i_clk = 1'b0;
    logic        i_reset, i_clear, i_stall, i_valid;
    logic [31:0] i_instruction, i_pc, i_bp_pc;
    logic        i_cpsr_t, i_instr_abort;
    logic        i_bp_confirm, i_bp_mispredict;
    logic [1:0]  i_bp_state;
    logic        o_ready, o_valid, o_instr_abort;
    logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
    logic [1:0]  o_taken_ff;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp8;
        logic        abort;
        logic [1:0]  taken;
    } exp_t;

    exp_t       q[$];
    logic [1:0] m_bp [1024];
    logic       m_sleep;
    int         errors = 0;
    int         checks = 0;

    localparam logic [1:0] MISP_TAB [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
    localparam logic [1:0] CONF_TAB [4] = '{2'd0, 2'd0, 2'd3, 2'd3};

    always #5 i_clk = ~i_clk;

    zap_fetch_buffered dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_clear         (i_clear),
        .i_stall         (i_stall),
        .i_valid         (i_valid),
        .i_instruction   (i_instruction),
        .i_pc            (i_pc),
        .i_cpsr_t        (i_cpsr_t),
        .i_instr_abort   (i_instr_abort),
        .o_ready         (o_ready),
        .o_valid         (o_valid),
        .o_instruction   (o_instruction),
        .o_instr_abort   (o_instr_abort),
        .o_pc_ff         (o_pc_ff),
        .o_pc_plus_8_ff  (o_pc_plus_8_ff),
        .o_taken_ff      (o_taken_ff),
        .i_bp_confirm    (i_bp_confirm),
        .i_bp_mispredict (i_bp_mispredict),
        .i_bp_pc         (i_bp_pc),
        .i_bp_state      (i_bp_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare outputs against the scoreboard, then advance the model by one clock.
    task automatic tick();
        exp_t e;
        logic rdy;
        #1;
        rdy = (q.size() != 4) && !m_sleep;
        check("valid", o_valid, q.size() != 0);
        check("ready", o_ready, rdy);
        if (q.size() != 0) begin
            e = q[0];
            check("instr", o_instruction, e.instr);
            check("pc", o_pc_ff, e.pc);
            check("pc8", o_pc_plus_8_ff, e.pcp8);
            check("abort", o_instr_abort, e.abort);
            check("taken", o_taken_ff, e.taken);
        end else begin
            check("instr_empty", o_instruction, 0);
            check("pc_empty", o_pc_ff, 0);
            check("pc8_empty", o_pc_plus_8_ff, 0);
            check("abort_empty", o_instr_abort, 0);
            check("taken_empty", o_taken_ff, 0);
        end
        if (i_clear) begin
            q.delete();
            m_sleep = 1'b0;
        end else begin
            if (q.size() != 0 && !i_stall)
                void'(q.pop_front());
            if (i_valid && rdy) begin
                e.instr = i_instr_abort ? 32'd0 : i_instruction;
                e.pc    = i_pc;
                e.pcp8  = i_pc + (i_cpsr_t ? 32'd4 : 32'd8);
                e.abort = i_instr_abort;
                e.taken = m_bp[i_pc[10:1]];
                q.push_back(e);
                if (i_instr_abort)
                    m_sleep = 1'b1;
            end
        end
        if ((i_bp_confirm || i_bp_mispredict) && !i_stall)
            m_bp[i_bp_pc[10:1]] = i_bp_mispredict ? MISP_TAB[i_bp_state] : CONF_TAB[i_bp_state];
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic t, input logic ab,
                         input logic st, input logic clr);
        i_valid       = v;
        i_pc          = pc;
        i_instruction = pc ^ 32'hE1A0_0000;
        i_cpsr_t      = t;
        i_instr_abort = ab;
        i_stall       = st;
        i_clear       = clr;
        tick();
    endtask

    task automatic bp_upd(input logic misp, input logic conf, input logic [1:0] st, input logic stall);
        i_bp_mispredict = misp;
        i_bp_confirm    = conf;
        i_bp_pc         = 32'h40;
        i_bp_state      = st;
        drive(0, 0, 0, 0, stall, 0);
        i_bp_mispredict = 0;
        i_bp_confirm    = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            m_bp[i] = 2'd0;
        m_sleep = 0;
        {i_clear, i_stall, i_valid, i_cpsr_t, i_instr_abort, i_bp_confirm, i_bp_mispredict} = '0;
        {i_instruction, i_pc, i_bp_pc, i_bp_state} = '0;
        i_reset = 1;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 0;
        drive(0, 0, 0, 0, 0, 0);

        // Fill under stall, fifth push refused, then drain in order.
        for (int i = 0; i < 5; i++)
            drive(1, 32'(i * 4), 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            drive(0, 0, 0, 0, 0, 0);

        // Steady push/pop at occupancy 2 across pointer wrap.
        drive(1, 32'h1000, 0, 0, 1, 0);
        drive(1, 32'h1004, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++)
            drive(1, 32'h1008 + 32'(i * 4), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 0, 0, 0, 0);

        // Abort puts the stage to sleep until a clear.
        drive(1, 32'h100, 0, 1, 1, 0);
        drive(1, 32'h104, 0, 0, 1, 0);
        drive(1, 32'h108, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Clear at count 3 discards a concurrent push.
        for (int i = 0; i < 3; i++)
            drive(1, 32'h200 + 32'(i * 4), 0, 0, 1, 0);
        drive(1, 32'h20C, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Thumb PC+4 and ARM wrap-around of PC+8.
        drive(1, 32'h2002, 1, 0, 0, 0);
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Predictor training at pc 0x40.
        bp_upd(1, 0, 2'b00, 0);
        bp_upd(1, 0, 2'b01, 0);
        drive(1, 32'h40, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        bp_upd(0, 1, 2'b10, 0);
        bp_upd(0, 1, 2'b00, 1);
        drive(1, 32'h40, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        bp_upd(1, 1, 2'b11, 0);
        drive(1, 32'h40, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Random mix over a small PC set so predictor state shows up at pushes.
        for (int i = 0; i < 80; i++) begin
            i_bp_mispredict = 1'($urandom);
            i_bp_confirm    = 1'($urandom);
            i_bp_pc         = 32'($urandom_range(0, 7)) << 1;
            i_bp_state      = 2'($urandom);
            drive(1'($urandom), 32'($urandom_range(0, 7)) << 1, 1'($urandom), 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        i_bp_mispredict = 0;
        i_bp_confirm    = 0;
        for (int i = 0; i < 6; i++)
            drive(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
